// File: rtl/inst_encoder.sv
// Packs instruction descriptors into 16-bit words and streams them into imem.
// Latency: a descriptor accepted in cycle N has its write request up in cycle N+2.
// Backpressure: mem_ready stalls the FIFO head; in_ready drops when stage+FIFO are full.

module inst_encoder_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [PW:0]   cnt_q;

   // Pointer and occupancy tracking; flush empties the queue in one cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset; the head is only looked at when count is non-zero.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= push_dat;
   end

   assign head  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

module inst_encoder #(
   parameter int AW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          in_last,
   input  logic [2:0]    in_fmt,
   input  logic [3:0]    in_op,
   input  logic [2:0]    in_ra,
   input  logic [2:0]    in_rb,
   input  logic [7:0]    in_imm,
   input  logic [2:0]    in_cond,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic          mem_ready,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_code,
   output logic [AW:0]   word_count
);
   localparam int PW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_ERR   = 2'd3;

   localparam logic [1:0] E_NONE = 2'b00;
   localparam logic [1:0] E_ILL  = 2'b01;
   localparam logic [1:0] E_IMM  = 2'b10;
   localparam logic [1:0] E_OVF  = 2'b11;

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   wc_q, wc_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic          stg_vld_q, stg_vld_d;
   logic [15:0]   stg_word_q, stg_word_d;
   logic [1:0]    stg_code_q, stg_code_d;

   logic [15:0]   enc_word;
   logic [1:0]    enc_code;
   logic          is_shift;
   logic [PW:0]   fifo_cnt;
   logic [PW:0]   occ;
   logic [15:0]   fifo_head;
   logic          active, fifo_full, fifo_empty;
   logic          accept, push, pop, stg_bad, ovf, fail, flush_done, last_addr;
   logic [1:0]    fail_code;

   // Field packing and reserved-encoding classification of the incoming descriptor.
   assign is_shift = (in_op[3:2] == 2'b10);
   always_comb begin
      enc_word = 16'h0;
      enc_code = E_NONE;
      case (in_fmt)
         3'd0: begin
            enc_word = {2'b11, in_ra, in_rb, in_op, (is_shift ? in_imm[3:0] : 4'h0)};
            if (in_op == 4'b0111 || in_op == 4'b1110)  enc_code = E_ILL;
            else if (is_shift && in_imm[7:4] != 4'h0)  enc_code = E_IMM;
         end
         3'd1:    enc_word = {2'b00, in_ra, in_rb, in_imm};
         3'd2:    enc_word = {2'b01, in_ra, in_rb, in_imm};
         3'd3:    enc_word = {2'b10, 3'b000, in_rb, in_imm};
         3'd4:    enc_word = {2'b10, 3'b100, 3'b000, in_imm};
         3'd5:    enc_word = {2'b10, 3'b111, in_cond, in_imm};
         default: enc_code = E_ILL;
      endcase
   end

   assign active     = (state_q == S_RUN) || (state_q == S_FLUSH);
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == (PW+1)'(DEPTH));
   // The encode stage is a slot of its own, so DEPTH+1 words fit before stalling.
   assign occ        = fifo_cnt + {{PW{1'b0}}, stg_vld_q};
   assign in_ready   = (state_q == S_RUN) && (occ <= (PW+1)'(DEPTH));
   assign accept     = in_valid && in_ready;
   assign mem_we     = active && !fifo_empty;
   assign pop        = mem_we && mem_ready;
   assign stg_bad    = stg_vld_q && (stg_code_q != E_NONE);
   assign push       = active && stg_vld_q && !stg_bad && (!fifo_full || pop);
   assign last_addr  = (addr_q == '1);
   // Writing the top word is fatal only if another word is still owed.
   assign ovf        = pop && last_addr &&
                       ((state_q == S_RUN) || stg_vld_q || (fifo_cnt > (PW+1)'(1)));
   assign fail       = active && (stg_bad || ovf);
   assign fail_code  = stg_bad ? stg_code_q : E_OVF;
   assign flush_done = (state_q == S_FLUSH) && !stg_vld_q && fifo_empty;

   inst_encoder_fifo #(.W(16), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (fail),
      .push     (push),
      .push_dat (stg_word_q),
      .pop      (pop),
      .head     (fifo_head),
      .count    (fifo_cnt)
   );

   // Encode stage: load on accept, drain into the FIFO, drop everything on error.
   always_comb begin
      stg_vld_d  = stg_vld_q;
      stg_word_d = stg_word_q;
      stg_code_d = stg_code_q;
      if (fail) begin
         stg_vld_d = 1'b0;
      end else if (accept) begin
         stg_vld_d  = 1'b1;
         stg_word_d = enc_word;
         stg_code_d = enc_code;
      end else if (push) begin
         stg_vld_d = 1'b0;
      end
   end

   // Load FSM, address counter and error reporting.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wc_d    = wc_q;
      err_d   = err_q;
      code_d  = code_q;
      if (pop) begin
         wc_d = wc_q + 1'b1;
         if (!last_addr) addr_d = addr_q + 1'b1;
      end
      case (state_q)
         S_IDLE, S_ERR: begin
            if (start) begin
               state_d = S_RUN;
               addr_d  = start_addr;
               wc_d    = '0;
               err_d   = 1'b0;
               code_d  = E_NONE;
            end
         end
         S_RUN: begin
            if (fail) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = fail_code;
            end else if (accept && in_last) begin
               state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if (fail) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               code_d  = fail_code;
            end else if (flush_done) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         wc_q       <= '0;
         err_q      <= 1'b0;
         code_q     <= E_NONE;
         stg_vld_q  <= 1'b0;
         stg_word_q <= 16'h0;
         stg_code_q <= E_NONE;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wc_q       <= wc_d;
         err_q      <= err_d;
         code_q     <= code_d;
         stg_vld_q  <= stg_vld_d;
         stg_word_q <= stg_word_d;
         stg_code_q <= stg_code_d;
      end
   end

   assign mem_addr   = addr_q;
   assign mem_wdata  = mem_we ? fifo_head : 16'h0;
   assign busy       = active;
   assign done       = flush_done;
   assign err        = err_q;
   assign err_code   = code_q;
   assign word_count = wc_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder against a program-level reference model.
// Drives and samples on the falling edge; writes are logged when mem_we&mem_ready.
// Load outcome (words, addresses, done/err) is predicted from the whole program.

module tb_inst_encoder;
   localparam int DEPTH = 4;

   logic        clk, rst, start;
   logic [7:0]  start_addr;
   logic        in_valid, in_ready, in_last;
   logic [2:0]  in_fmt, in_ra, in_rb, in_cond;
   logic [3:0]  in_op;
   logic [7:0]  in_imm;
   logic        mem_we, mem_ready, busy, done, err;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  err_code;
   logic [8:0]  word_count;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [2:0] fmt;
      logic [3:0] op;
      logic [2:0] ra;
      logic [2:0] rb;
      logic [7:0] imm;
      logic [2:0] cond;
   } desc_t;

   desc_t prog[$];

   inst_encoder #(.AW(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_fmt(in_fmt), .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb),
      .in_imm(in_imm), .in_cond(in_cond),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
      .err_code(err_code), .word_count(word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic desc_t mk(input int fmt, input int op, input int ra, input int rb,
                                input int imm, input int cond);
      desc_t d;
      d.fmt = 3'(fmt); d.op = 4'(op); d.ra = 3'(ra); d.rb = 3'(rb);
      d.imm = 8'(imm); d.cond = 3'(cond);
      return d;
   endfunction

   // Instruction word from the field layout of each format, by place value.
   function automatic logic [15:0] enc(input desc_t d);
      int w;
      int ra = int'(d.ra), rb = int'(d.rb), op = int'(d.op);
      int imm = int'(d.imm), cond = int'(d.cond);
      case (int'(d.fmt))
         0: w = 3*16384 + ra*2048 + rb*256 + op*16 + ((op >= 8 && op <= 11) ? imm % 16 : 0);
         1: w = 0*16384 + ra*2048 + rb*256 + imm;
         2: w = 1*16384 + ra*2048 + rb*256 + imm;
         3: w = 2*16384 + rb*256 + imm;
         4: w = 2*16384 + 4*2048 + imm;
         5: w = 2*16384 + 7*2048 + cond*256 + imm;
         default: w = 0;
      endcase
      return 16'(w);
   endfunction

   function automatic int exp_code(input desc_t d);
      if (d.fmt >= 3'd6) return 1;
      if (d.fmt == 3'd0 && (d.op == 4'd7 || d.op == 4'd14)) return 1;
      if (d.fmt == 3'd0 && d.op >= 4'd8 && d.op <= 4'd11 && d.imm >= 8'd16) return 2;
      return 0;
   endfunction

   function automatic desc_t rnd_legal();
      desc_t d;
      d = mk($urandom_range(5), $urandom_range(15), $urandom_range(7), $urandom_range(7),
             $urandom_range(255), $urandom_range(7));
      while (d.op == 4'd7 || d.op == 4'd14) d.op = 4'($urandom_range(15));
      if (d.fmt == 3'd0 && d.op >= 4'd8 && d.op <= 4'd11) d.imm = 8'($urandom_range(15));
      return d;
   endfunction

   function automatic desc_t rnd_illegal();
      desc_t d;
      d = rnd_legal();
      case ($urandom_range(2))
         0: d.fmt = 3'(6 + $urandom_range(1));
         1: begin d.fmt = 3'd0; d.op = ($urandom_range(1) == 0) ? 4'd7 : 4'd14; end
         default: begin
            d.fmt = 3'd0; d.op = 4'(8 + $urandom_range(3)); d.imm = 8'(16 + $urandom_range(239));
         end
      endcase
      return d;
   endfunction

   task automatic idle_inputs();
      in_valid = 1'b0; in_last = 1'b0; in_fmt = '0; in_op = '0; in_ra = '0;
      in_rb = '0; in_imm = '0; in_cond = '0;
   endtask

   // Runs one load of prog[] and compares its outcome with the program-level prediction.
   task automatic run_load(input logic [7:0] sa, input int rdy_pct, input int stall_cyc,
                           input bit lat_chk);
      int n = prog.size();
      int idx = 0, acc_cyc = -1, we_cyc = -1, dones = 0;
      int lill, cap, w, code, m;
      bit finished = 0, hold = 0;
      logic [15:0] hold_dat = '0;
      logic [23:0] obs[$];

      @(negedge clk);
      start = 1'b1; start_addr = sa; mem_ready = 1'b0; idle_inputs();
      @(negedge clk);
      start = 1'b0;
      chk("start_err", 32'(err), 0);
      chk("start_code", 32'(err_code), 0);
      chk("start_wc", 32'(word_count), 0);
      chk("start_busy", 32'(busy), 1);
      chk("start_addr", 32'(mem_addr), 32'(sa));

      for (int cyc = 0; cyc < 400; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (done) dones++;
         if (hold) begin
            chk("hold_we", 32'(mem_we), 1);
            chk("hold_dat", 32'(mem_wdata), 32'(hold_dat));
         end
         if (done || err) begin
            finished = 1;
            idle_inputs();
            break;
         end
         if (stall_cyc > 0 && cyc == stall_cyc) begin
            chk("stall_accepted", 32'(idx), DEPTH + 1);
            chk("stall_in_ready", 32'(in_ready), 0);
         end
         mem_ready = (cyc < stall_cyc) ? 1'b0 : ($urandom_range(99) < rdy_pct);
         if (mem_we && we_cyc < 0) we_cyc = cyc;
         if (mem_we && mem_ready) obs.push_back({mem_addr, mem_wdata});
         hold = mem_we && !mem_ready;
         hold_dat = mem_wdata;
         if (idx < n && (cyc < stall_cyc || $urandom_range(3) != 0)) begin
            in_valid = 1'b1;
            in_last = (idx == n - 1);
            in_fmt = prog[idx].fmt; in_op = prog[idx].op; in_ra = prog[idx].ra;
            in_rb = prog[idx].rb; in_imm = prog[idx].imm; in_cond = prog[idx].cond;
         end else begin
            idle_inputs();
         end
         if (in_valid && in_ready) begin
            if (acc_cyc < 0) acc_cyc = cyc;
            idx++;
         end
      end
      if (!finished) chk("load_timeout", 1, 0);

      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         if (done) dones++;
         if (mem_we) obs.push_back({mem_addr, mem_wdata});
      end

      lill = n;
      for (int i = 0; i < n; i++) if (exp_code(prog[i]) != 0) begin lill = i; break; end
      cap = 256 - int'(sa);
      if (lill < n)     begin w = lill; code = exp_code(prog[lill]); end
      else if (n > cap) begin w = cap;  code = 3; end
      else              begin w = n;    code = 0; end

      chk("n_writes", 32'(obs.size()), 32'(w));
      m = (obs.size() < w) ? obs.size() : w;
      for (int i = 0; i < m; i++) begin
         chk("wr_addr", 32'(obs[i][23:16]), 32'((int'(sa) + i) % 256));
         chk("wr_data", 32'(obs[i][15:0]), 32'(enc(prog[i])));
      end
      chk("done_pulses", 32'(dones), (code == 0) ? 1 : 0);
      chk("err", 32'(err), (code != 0) ? 1 : 0);
      chk("err_code", 32'(err_code), 32'(code));
      chk("word_count", 32'(word_count), 32'(w));
      chk("busy_end", 32'(busy), 0);
      chk("in_ready_end", 32'(in_ready), 0);
      if (lat_chk) chk("first_we_latency", 32'(we_cyc - acc_cyc), 2);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_addr = '0; mem_ready = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_err_code", 32'(err_code), 0);
      chk("rst_word_count", 32'(word_count), 0);
      rst = 1'b0;

      // ADD then LD, first-write latency
      prog = {};
      prog.push_back(mk(0, 0, 1, 2, 0, 0));
      prog.push_back(mk(1, 0, 4, 5, 8'h10, 0));
      run_load(8'h10, 100, 0, 1);

      // SLL, LI, BCC
      prog = {};
      prog.push_back(mk(0, 8, 0, 3, 5, 0));
      prog.push_back(mk(3, 0, 0, 7, 8'h2A, 0));
      prog.push_back(mk(5, 0, 0, 0, 8'hFE, 1));
      run_load(8'h20, 100, 0, 0);

      // write port held off: DEPTH+1 accepted, head stable, then full drain
      prog = {};
      for (int i = 0; i < 8; i++) prog.push_back(rnd_legal());
      run_load(8'h40, 60, 10, 0);

      // reserved opcode as third descriptor; the next start clears err
      prog = {};
      prog.push_back(rnd_legal());
      prog.push_back(rnd_legal());
      prog.push_back(mk(0, 7, 1, 1, 0, 0));
      prog.push_back(rnd_legal());
      run_load(8'h50, 100, 0, 0);

      // shift amount out of range, then an illegal format
      prog = {};
      prog.push_back(mk(0, 11, 2, 3, 8'h15, 0));
      run_load(8'h60, 100, 0, 0);
      prog = {};
      prog.push_back(mk(6, 0, 0, 0, 0, 0));
      run_load(8'h60, 100, 0, 0);

      // top of address space: overflow versus clean completion
      prog = {};
      for (int i = 0; i < 3; i++) prog.push_back(rnd_legal());
      run_load(8'hFE, 100, 0, 0);
      prog = {};
      for (int i = 0; i < 2; i++) prog.push_back(rnd_legal());
      run_load(8'hFE, 100, 0, 0);

      // randomized programs
      for (int t = 0; t < 20; t++) begin
         int n = 1 + $urandom_range(7);
         prog = {};
         for (int i = 0; i < n; i++) prog.push_back(rnd_legal());
         if ($urandom_range(3) == 0) begin
            prog[$urandom_range(n - 1)] = rnd_illegal();
            run_load(8'($urandom_range(200)), 100, 0, 0);
         end else if ($urandom_range(3) == 0) begin
            run_load(8'(256 - 1 - $urandom_range(5)), 30 + $urandom_range(70), 0, 0);
         end else begin
            run_load(8'($urandom_range(200)), 30 + $urandom_range(70), 0, 0);
         end
      end

      // reset in the middle of a load
      prog = {};
      for (int i = 0; i < 6; i++) prog.push_back(rnd_legal());
      @(negedge clk);
      start = 1'b1; start_addr = 8'h80;
      @(negedge clk);
      start = 1'b0; mem_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
      in_fmt = prog[0].fmt; in_op = prog[0].op; in_ra = prog[0].ra;
      in_rb = prog[0].rb; in_imm = prog[0].imm; in_cond = prog[0].cond;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_mem_we", 32'(mem_we), 0);
      chk("midrst_wc", 32'(word_count), 0);
      chk("midrst_addr", 32'(mem_addr), 0);
      chk("midrst_in_ready", 32'(in_ready), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("midrst_no_write", 32'(mem_we), 0);
      end
      idle_inputs();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
